riscv_div_iter: RTL and testbench

- Parametrised multi-cycle integer divide/remainder unit for the EX stage.
- Executes ALU_DIVU, ALU_DIV, ALU_REMU and ALU_REM. Op bit 0 selects signed; op bit 1 selects remainder.
- Generalises the single fixed 32-bit divider to any operand width and a configurable number of quotient bits per cycle.
- Uses valid/ready on both sides so the ID/EX stall logic can back-pressure it.

---
 rtl/riscv_defines.sv | 26 ++
 rtl/riscv_div_step.sv | 22 ++
 rtl/riscv_div_iter.sv | 168 ++++++++++++++++
 tb/tb_riscv_div_iter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared ALU operator encodings and divider definitions.
package riscv_defines;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

  localparam int DIV_OP_SIGNED_BIT = 0;
  localparam int DIV_OP_REM_BIT    = 1;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_DIVU) || (op == ALU_DIV) || (op == ALU_REMU) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference if it did not borrow.
module riscv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  // The shifted partial remainder needs WIDTH+1 bits so divisors with the MSB set work.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, quot_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_i};
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_o  = {quot_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/riscv_div_iter.sv
// Multi-cycle signed/unsigned divide and remainder unit with valid/ready handshakes.
// Optional leading-zero early-out is enabled by defining RISCV_DIV_EARLY_OUT_EN.
module riscv_div_iter
  import riscv_defines::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_WIDTH-1:0] op_i,
  input  logic [WIDTH-1:0]        op_a_i,
  input  logic [WIDTH-1:0]        op_b_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        result_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  div_state_t       state_reg;
  logic             op_signed_reg, op_rem_reg;
  logic [WIDTH-1:0] a_reg, b_reg, quot_reg, rem_reg, result_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg, neg_r_reg;
  logic             result_valid_reg, ready_reg;

  logic             a_neg, b_neg, div_zero, overflow, skip_iter;
  logic [WIDTH-1:0] a_abs, b_abs, prep_quot, q_fix, r_fix;
  logic [CNT_W-1:0] prep_cnt;

  always_comb begin
    a_neg    = op_signed_reg & a_reg[WIDTH-1];
    b_neg    = op_signed_reg & b_reg[WIDTH-1];
    a_abs    = a_neg ? -a_reg : a_reg;
    b_abs    = b_neg ? -b_reg : b_reg;
    div_zero = (b_reg == '0);
    overflow = op_signed_reg && (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (b_reg == '1);
    q_fix    = neg_q_reg ? -quot_reg : quot_reg;
    r_fix    = neg_r_reg ? -rem_reg : rem_reg;
  end

`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam int LZ_W = $clog2(WIDTH + 1);
  logic [LZ_W-1:0] lz, lz_round;

  // Skip leading zero groups of |a|; a zero dividend needs no iterations at all.
  always_comb begin
    lz = LZ_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a_abs[i]) lz = LZ_W'(WIDTH - 1 - i);
    end
    lz_round  = lz & ~LZ_W'(BITS_PER_CYCLE - 1);
    prep_quot = a_abs << lz_round;
    prep_cnt  = CNT_W'((WIDTH - int'(lz_round)) / BITS_PER_CYCLE);
    skip_iter = (a_abs == '0);
  end
`else
  always_comb begin
    prep_quot = a_abs;
    prep_cnt  = CNT_W'(STEPS);
    skip_iter = 1'b0;
  end
`endif

  logic [WIDTH-1:0] rem_chain  [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quot_chain [BITS_PER_CYCLE+1];

  assign rem_chain[0]  = rem_reg;
  assign quot_chain[0] = quot_reg;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      riscv_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_chain[gi]),
        .quot_i (quot_chain[gi]),
        .div_i  (b_reg),
        .rem_o  (rem_chain[gi+1]),
        .quot_o (quot_chain[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= DIV_IDLE;
      op_signed_reg    <= 1'b0;
      op_rem_reg       <= 1'b0;
      a_reg            <= '0;
      b_reg            <= '0;
      quot_reg         <= '0;
      rem_reg          <= '0;
      result_reg       <= '0;
      cnt_reg          <= '0;
      neg_q_reg        <= 1'b0;
      neg_r_reg        <= 1'b0;
      result_valid_reg <= 1'b0;
      ready_reg        <= 1'b1;
    end else if (flush_i && state_reg != DIV_IDLE) begin
      state_reg        <= DIV_IDLE;
      result_valid_reg <= 1'b0;
      ready_reg        <= 1'b1;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (valid_i && ready_reg && !flush_i) begin
            // Illegal operators fall back to DIVU.
            op_signed_reg <= is_div_op(op_i) & op_i[DIV_OP_SIGNED_BIT];
            op_rem_reg    <= is_div_op(op_i) & op_i[DIV_OP_REM_BIT];
            a_reg         <= op_a_i;
            b_reg         <= op_b_i;
            ready_reg     <= 1'b0;
            state_reg     <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          // Special results are parked in quot/rem with no sign fix so FIX passes them through.
          if (div_zero || overflow) begin
            quot_reg  <= div_zero ? '1 : a_reg;
            rem_reg   <= div_zero ? a_reg : '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            state_reg <= DIV_FIX;
          end else begin
            b_reg     <= b_abs;
            quot_reg  <= prep_quot;
            rem_reg   <= '0;
            cnt_reg   <= prep_cnt;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            state_reg <= skip_iter ? DIV_FIX : DIV_ITER;
          end
        end
        DIV_ITER: begin
          rem_reg  <= rem_chain[BITS_PER_CYCLE];
          quot_reg <= quot_chain[BITS_PER_CYCLE];
          cnt_reg  <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_reg <= DIV_FIX;
        end
        DIV_FIX: begin
          result_reg       <= op_rem_reg ? r_fix : q_fix;
          result_valid_reg <= 1'b1;
          state_reg        <= DIV_DONE;
        end
        DIV_DONE: begin
          if (result_ready_i) begin
            result_valid_reg <= 1'b0;
            ready_reg        <= 1'b1;
            state_reg        <= DIV_IDLE;
          end
        end
        default: state_reg <= DIV_IDLE;
      endcase
    end
  end

  assign ready_o        = ready_reg;
  assign result_o       = result_reg;
  assign result_valid_o = result_valid_reg;

  assert property (@(posedge clk) disable iff (rst)
    (valid_i && ready_o && !flush_i) |-> is_div_op(op_i));

endmodule

// File: tb/tb_riscv_div_iter.sv
// Randomised and directed bench for riscv_div_iter at 32/1 and 16/4 configurations.
module tb_riscv_div_iter;
  import riscv_defines::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [ALU_OP_WIDTH-1:0] op = ALU_DIVU;
  logic [31:0] a = '0, b = '0, result;
  logic valid = 1'b0, flush = 1'b0, result_ready = 1'b0, ready, result_valid;

  logic [ALU_OP_WIDTH-1:0] op16 = ALU_DIVU;
  logic [15:0] a16 = '0, b16 = '0, result16;
  logic valid16 = 1'b0, flush16 = 1'b0, result_ready16 = 1'b0, ready16, result_valid16;

  int total = 0;
  int bad = 0;

  riscv_div_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .op_i(op), .op_a_i(a), .op_b_i(b), .valid_i(valid),
    .ready_o(ready), .flush_i(flush), .result_o(result),
    .result_valid_o(result_valid), .result_ready_i(result_ready)
  );

  riscv_div_iter #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst(rst), .op_i(op16), .op_a_i(a16), .op_b_i(b16), .valid_i(valid16),
    .ready_o(ready16), .flush_i(flush16), .result_o(result16),
    .result_valid_o(result_valid16), .result_ready_i(result_ready16)
  );

  // Reference: RISC-V M-extension semantics evaluated with 64-bit arithmetic.
  function automatic logic [31:0] ref_div32(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (y == 0) return o[1] ? x : 32'hFFFFFFFF;
    if (o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return o[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int ref_lat32(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mag;
    int lz;
    if (y == 0 || (o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)) return 2;
    mag = (o[0] && x[31]) ? -x : x;
    lz = 0;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) break;
      lz++;
    end
`ifdef RISCV_DIV_EARLY_OUT_EN
    return 2 + (32 - lz);
`else
    return (lz >= 0) ? 34 : 0;
`endif
  endfunction

  function automatic int ref_lat16(input logic [15:0] x, input logic [15:0] y);
    int lz;
    if (y == 0) return 2;
    lz = 0;
    for (int i = 15; i >= 0; i--) begin
      if (x[i]) break;
      lz++;
    end
`ifdef RISCV_DIV_EARLY_OUT_EN
    return 2 + (16 - (lz / 4) * 4) / 4;
`else
    return (lz >= 0) ? 6 : 0;
`endif
  endfunction

  // Called at posedge+1; returns result and cycles from accept edge to result_valid (-1 on timeout).
  task automatic do_op(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready op=%h got ready=%b want 1", o, ready);
    end
    total++;
    op = o; a = x; b = y; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) begin
        lat = c;
        res = result;
        break;
      end
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic do_op16(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] res, output int lat);
    op16 = ALU_DIVU; a16 = x; b16 = y; valid16 = 1'b1;
    @(posedge clk); #1;
    valid16 = 1'b0;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (result_valid16 === 1'b1) begin
        lat = c;
        res = result16;
        break;
      end
    end
    result_ready16 = 1'b1;
    @(posedge clk); #1;
    result_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready); end
    total++;
    if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", result_valid); end
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 0", result); end
    total++;
    if (ready16 !== 1'b1 || result_valid16 !== 1'b0 || result16 !== 16'h0) begin
      bad++; $display("FAIL reset_w16 got ready=%b valid=%b result=%h want 1 0 0", ready16, result_valid16, result16);
    end
    total++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [6:0]  ops [9]  = '{ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM, ALU_REM, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU};
    logic [31:0] xs  [9]  = '{32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C, 32'd100, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
    logic [31:0] ys  [9]  = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] exp [9]  = '{32'd14, 32'd2, 32'hFFFFFFF2, 32'hFFFFFFFE, 32'd2, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 9; i++) begin
      do_op(ops[i], xs[i], ys[i], res, lat);
      $display("directed op=%h a=%h b=%h result=%h lat=%0d", ops[i], xs[i], ys[i], res, lat);
      if (res !== exp[i]) begin bad++; $display("FAIL directed_result[%0d] got %h want %h", i, res, exp[i]); end
      total++;
      if (lat !== ref_lat32(ops[i], xs[i], ys[i])) begin
        bad++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, ref_lat32(ops[i], xs[i], ys[i]));
      end
      total++;
    end
  endtask

  task automatic test_random();
    logic [6:0]  o;
    logic [31:0] x, y, res, exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      o = ALU_DIVU | 7'($urandom_range(0, 3));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFFFFFF;
        3: y = x >> $urandom_range(0, 31);
        4: y = $urandom | 32'h80000000;
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      exp = ref_div32(o, x, y);
      do_op(o, x, y, res, lat);
      $display("random op=%h a=%h b=%h result=%h lat=%0d", o, x, y, res, lat);
      if (res !== exp) begin bad++; $display("FAIL random_result[%0d] got %h want %h", i, res, exp); end
      total++;
      if (lat !== ref_lat32(o, x, y)) begin
        bad++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, ref_lat32(o, x, y));
      end
      total++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    bit seen;
    op = ALU_DIVU; a = 32'd1000; b = 32'd9; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      seen = (result_valid === 1'b1);
    end
    if (!seen) begin bad++; $display("FAIL bp_timeout got no result_valid want result_valid"); end
    total++;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (result !== 32'd111 || result_valid !== 1'b1 || ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got result=%h valid=%b ready=%b want 6f 1 0", c, result, result_valid, ready);
      end
      total++;
    end
    result_ready = 1'b1;
    op = ALU_DIVU; a = 32'd50; b = 32'd5; valid = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    valid = 1'b0;
    if (result_valid !== 1'b0 || ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", result_valid, ready);
    end
    total++;
    $display("backpressure hold=10 result=%h", 32'd111);
    do_op(ALU_DIVU, 32'd9, 32'd3, res, lat);
    if (res !== 32'd3) begin bad++; $display("FAIL bp_next got %h want 3", res); end
    total++;
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    bit leaked;
    op = ALU_DIVU; a = 32'hDEADBEEF; b = 32'd13; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (ready !== 1'b1 || result_valid !== 1'b0) begin
      bad++; $display("FAIL flush_iter got ready=%b valid=%b want 1 0", ready, result_valid);
    end
    total++;
    op = ALU_DIVU; a = 32'd77; b = 32'd7; valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    if (ready !== 1'b1) begin bad++; $display("FAIL flush_idle_accept got ready=%b want 1", ready); end
    total++;
    leaked = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) leaked = 1'b1;
    end
    if (leaked) begin bad++; $display("FAIL flush_no_result got result_valid=1 want 0"); end
    total++;
    do_op(ALU_DIVU, 32'd9, 32'd3, res, lat);
    $display("flush then DIVU 9/3 result=%h lat=%0d", res, lat);
    if (res !== 32'd3) begin bad++; $display("FAIL flush_next got %h want 3", res); end
    total++;
  endtask

  task automatic test_rst_mid();
    op = ALU_REM; a = 32'h12345678; b = 32'd11; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    if (ready !== 1'b1 || result_valid !== 1'b0 || result !== 32'h0) begin
      bad++; $display("FAIL rst_mid got ready=%b valid=%b result=%h want 1 0 0", ready, result_valid, result);
    end
    total++;
    $display("reset mid-operation ready=%b valid=%b", ready, result_valid);
  endtask

  task automatic test_w16();
    logic [15:0] x, y, res;
    int lat;
    do_op16(16'hFFFF, 16'h0003, res, lat);
    $display("w16 DIVU ffff/0003 result=%h lat=%0d", res, lat);
    if (res !== 16'h5555) begin bad++; $display("FAIL w16_result got %h want 5555", res); end
    total++;
    if (lat !== ref_lat16(16'hFFFF, 16'h0003)) begin bad++; $display("FAIL w16_latency got %0d want %0d", lat, ref_lat16(16'hFFFF, 16'h0003)); end
    total++;
    for (int i = 0; i < 10; i++) begin
      x = 16'($urandom);
      y = (i == 3) ? 16'h0 : 16'($urandom >> $urandom_range(16, 31));
      do_op16(x, y, res, lat);
      $display("w16 DIVU %h/%h result=%h lat=%0d", x, y, res, lat);
      if (res !== ((y == 0) ? 16'hFFFF : x / y)) begin
        bad++; $display("FAIL w16_random[%0d] got %h want %h", i, res, (y == 0) ? 16'hFFFF : x / y);
      end
      total++;
      if (lat !== ref_lat16(x, y)) begin bad++; $display("FAIL w16_rand_lat[%0d] got %0d want %0d", i, lat, ref_lat16(x, y)); end
      total++;
    end
  endtask

  task automatic test_early_out();
    logic [31:0] res;
    int lat;
    do_op(ALU_DIVU, 32'd5, 32'd1, res, lat);
    $display("early-out DIVU 5/1 result=%h lat=%0d", res, lat);
    if (res !== 32'd5) begin bad++; $display("FAIL early_result got %h want 5", res); end
    total++;
`ifdef RISCV_DIV_EARLY_OUT_EN
    if (lat < 2 || lat >= 34) begin bad++; $display("FAIL early_latency got %0d want 2..33", lat); end
`else
    if (lat !== 34) begin bad++; $display("FAIL early_latency got %0d want 34", lat); end
`endif
    total++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_w16();
    test_early_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
